uart_tx_unit: RTL

UART_TX_UNIT -- requirements
Module: uart_tx_unit

---
 rtl/uart_tx_unit.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_unit.sv
// uart_tx_unit: FIFO-buffered UART transmitter driven by a 16x oversampling tick.
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
`timescale 1ns/1ps
module uart_tx_unit #(
    parameter int unsigned DBIT    = 8,
    parameter int unsigned SB_TICK = 16,
    parameter int unsigned DVSR    = 163,
    parameter int unsigned FIFO_W  = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wr_uart,
    input  logic [DBIT-1:0] w_data,
    output logic            tx_full,
    output logic            tx_empty,
    output logic            tx_done_tick,
    output logic            tx
);
    localparam int unsigned DEPTH  = 2 ** FIFO_W;
    localparam int unsigned CNT_W  = FIFO_W + 1;
    localparam int unsigned BAUD_W = (DVSR > 1) ? $clog2(DVSR) : 1;
    localparam int unsigned TICK_W = $clog2((SB_TICK > 16) ? SB_TICK : 16);
    localparam int unsigned BIT_W  = (DBIT > 1) ? $clog2(DBIT) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t              state_q, state_n;
    logic [BAUD_W-1:0]   baud_q;
    logic                s_tick;
    logic [TICK_W-1:0]   tick_q, tick_n;
    logic [BIT_W-1:0]    bit_q, bit_n;
    logic [DBIT-1:0]     shift_q, shift_n;
    logic                tx_q, tx_n;
    logic                done_q, done_n;
`ifdef UART_TX_PARITY_EN
    logic                parity_q, parity_n;
`endif

    logic [DBIT-1:0]     mem [DEPTH];
    logic [FIFO_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]    count_q, count_n;
    logic                full_q, empty_q;
    logic                push, pop;
    logic                fifo_has_data;

    // Free-running oversampling tick generator
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            baud_q <= '0;
        end else if (baud_q == BAUD_W'(DVSR - 1)) begin
            baud_q <= '0;
        end else begin
            baud_q <= baud_q + BAUD_W'(1);
        end
    end

    assign s_tick = (baud_q == BAUD_W'(DVSR - 1));

    // FIFO occupancy bookkeeping; a write while full is dropped even if a pop happens
    always_comb begin
        push          = wr_uart & ~full_q;
        fifo_has_data = (count_q != '0);
        count_n       = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    // FIFO storage (no reset needed: occupancy gates every read)
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= w_data;
        end
    end

    // FIFO pointers, occupancy and registered status flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + FIFO_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + FIFO_W'(1);
            count_q  <= count_n;
            full_q   <= (count_n == CNT_W'(DEPTH));
            empty_q  <= (count_n == '0) && (state_n == IDLE);
        end
    end

    // Serializer state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            tick_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_n;
            tick_q   <= tick_n;
            bit_q    <= bit_n;
            shift_q  <= shift_n;
            tx_q     <= tx_n;
            done_q   <= done_n;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_n;
`endif
        end
    end

    // Serializer next state; tx is decoded from the next state so the line changes with the state
    always_comb begin
        state_n  = state_q;
        tick_n   = tick_q;
        bit_n    = bit_q;
        shift_n  = shift_q;
        done_n   = 1'b0;
        pop      = 1'b0;
        tx_n     = 1'b1;
`ifdef UART_TX_PARITY_EN
        parity_n = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (fifo_has_data) begin
                    shift_n  = mem[rd_ptr_q];
                    pop      = 1'b1;
                    tick_n   = '0;
                    state_n  = START;
`ifdef UART_TX_PARITY_EN
                    parity_n = ^mem[rd_ptr_q];
`endif
                end
            end
            START: begin
                if (s_tick) begin
                    if (tick_q == TICK_W'(15)) begin
                        tick_n  = '0;
                        bit_n   = '0;
                        state_n = DATA;
                    end else begin
                        tick_n = tick_q + TICK_W'(1);
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (tick_q == TICK_W'(15)) begin
                        tick_n  = '0;
                        shift_n = shift_q >> 1;
                        if (bit_q == BIT_W'(DBIT - 1)) begin
`ifdef UART_TX_PARITY_EN
                            state_n = PARITY;
`else
                            state_n = STOP;
`endif
                        end else begin
                            bit_n = bit_q + BIT_W'(1);
                        end
                    end else begin
                        tick_n = tick_q + TICK_W'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (s_tick) begin
                    if (tick_q == TICK_W'(15)) begin
                        tick_n  = '0;
                        state_n = STOP;
                    end else begin
                        tick_n = tick_q + TICK_W'(1);
                    end
                end
            end
`endif
            STOP: begin
                if (s_tick) begin
                    if (tick_q == TICK_W'(SB_TICK - 1)) begin
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end else begin
                        tick_n = tick_q + TICK_W'(1);
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shift_n[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_n = parity_n;
`endif
            default: tx_n = 1'b1;
        endcase
    end

    assign tx           = tx_q;
    assign tx_done_tick = done_q;
    assign tx_full      = full_q;
    assign tx_empty     = empty_q;

endmodule
